// File: rtl/dmem_lsu.sv
// Load/store unit: turns core data-memory accesses into word-aligned valid/ready bus transactions.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of issuing them.
module dmem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dmem_rw_addr,
  input  logic [31:0] rs2_data,
  input  logic        dmem_w_en,
  input  logic        ld_en,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_r_data,
  output logic        stall,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers in a cycle where bus_req && bus_ready; bus_req and all
  // bus_* outputs hold steady until then. Read data transfers in any cycle with bus_rvalid
  // after (or together with) that acceptance.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             start, trap, capture, timeout, misalign, cnt_expired, stall_c;
  logic [3:0]       be_in;
  logic [31:0]      wdata_in;
  logic [1:0]       shift;
  logic [31:0]      shifted, load_ext;

  // funct3[1:0]: 00 byte, 01 half, 1x word (unused codes fall into word)
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << dmem_rw_addr[1:0];
        wdata_in = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {dmem_rw_addr[1], 1'b0};
        wdata_in = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && dmem_rw_addr[0]) ||
                    (funct3[1] && (dmem_rw_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Halfwords ignore addr[0] and words ignore addr[1:0] when extracting read data
  always_comb begin
    case (size_q)
      2'b00:   shift = off_q;
      2'b01:   shift = {off_q[1], 1'b0};
      default: shift = 2'b00;
    endcase
    shifted = bus_rdata >> {shift, 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Completion in the final allowed cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    start   = 1'b0;
    trap    = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_en || dmem_w_en) begin
          stall_c = 1'b1;
          if (misalign) begin
            trap    = 1'b1;
            state_d = S_DONE;
          end else begin
            start   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (bus_ready) begin
          if (bus_we) begin
            state_d = S_DONE;
          end else if (bus_rvalid) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_expired) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (bus_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (cnt_expired) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stall     = stall_c & reset_n;
  assign dbg_state = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      bus_be      <= 4'b0000;
      dmem_r_data <= 32'h0;
      lsu_err     <= 1'b0;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      lsu_err <= trap | timeout;
      if (start) begin
        cnt_q <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= dmem_w_en;
        bus_addr  <= {dmem_rw_addr[31:2], 2'b00};
        bus_wdata <= wdata_in;
        bus_be    <= be_in;
        off_q     <= dmem_rw_addr[1:0];
        size_q    <= funct3[1:0];
        uns_q     <= funct3[2];
      end else if (state_q == S_REQ && (bus_ready || timeout)) begin
        bus_req <= 1'b0;
      end
      if (capture) begin
        dmem_r_data <= load_ext;
      end else if (timeout && !bus_we) begin
        dmem_r_data <= 32'h0;
      end
    end
  end

endmodule
